// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
// Shared definitions for the MIPS-style datapath: ALU operation codes and
// the state encoding of the multi-cycle multiply sequencer.
// No ports; imported by alu_mult_sequencer and by its testbench.

package mips_alu_pkg;

    // ALU operation codes understood by the shared ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b0111;

    // Multiply sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
// Computes the low word of req_a*req_b by driving the shared ALU through
// shift-add steps, one ALU operation per clock.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake, req_a multiplicand, req_b multiplier
//   resp_valid/resp_ready, resp_product   response handshake and product
//   busy                 high while the ALU is being used by this block
//   alu_op/alu_a/alu_b   operation and operands presented to the ALU
//   alu_result/alu_zero  combinational ALU result and zero flag
//
// Configuration macro: ALU_MULT_EARLY_EXIT_EN
//   defined   - stop as soon as the remaining multiplier becomes zero
//   undefined - always run DATA_W iterations; alu_zero is ignored

module alu_mult_sequencer
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_product,
    output logic              busy,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    seq_state_t        state, state_next;
    logic [DATA_W-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0]  cnt;
    logic              last_iter;
    logic              finish;

    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

`ifdef ALU_MULT_EARLY_EXIT_EN
    // alu_zero during SHR means the shifted multiplier has no set bits left
    assign finish = last_iter || alu_zero;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign finish = last_iter;
`endif

    // State register plus datapath registers; each working state writes
    // the ALU result back into the register it was operating on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mcand  <= req_a;
                        mplier <= req_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_ADD:  acc   <= alu_result;
                ST_SHL:  mcand <= alu_result;
                ST_SHR: begin
                    mplier <= alu_result;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode. ALU outputs rest at ADD/0/0 outside
    // the working states so the parent sees stable values when not granted.
    // In SHR, bit 0 of the freshly shifted multiplier picks the next step.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_product = '0;
        busy         = 1'b0;
        alu_op       = ALU_ADD;
        alu_a        = '0;
        alu_b        = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_b[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_ADD: begin
                busy       = 1'b1;
                alu_op     = ALU_ADD;
                alu_a      = acc;
                alu_b      = mcand;
                state_next = ST_SHL;
            end
            ST_SHL: begin
                busy       = 1'b1;
                alu_op     = ALU_SLL;
                alu_a      = mcand;
                alu_b      = DATA_W'(1);
                state_next = ST_SHR;
            end
            ST_SHR: begin
                busy   = 1'b1;
                alu_op = ALU_SRL;
                alu_a  = mplier;
                alu_b  = DATA_W'(1);
                if (finish) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = alu_result[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_DONE: begin
                resp_valid   = 1'b1;
                resp_product = acc;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
